logistic_snd_multi: RTL
=======================

Name: logistic_snd_multi

Overview:
Second-generation logistic-map sonifier. It iterates x(n+1) = r·x(n)·(1 − x(n)) in fixed point on a programmable pacing tick. It sweeps r between runtime bounds in one of four modes and maps each new x round-robin onto N_OSC phase-accumulator square-wave oscillators. The enabled oscillators are mixed by a first-order sigma-delta into one PWM audio bit for the top-level output pin.

Parameters:
N_OSC, 4, number of oscillators (1..16)
FRAC, 8, fractional bits of x (0.FRAC) and r (2.FRAC)
PHASE_BITS, 12, oscillator phase accumulator width
PHASE_DEC, 7, log2 of clocks per oscillator phase step
ITER_DIV, 4096, clocks per map iteration (≥2)
LO_INC, 8, phase increment for x = 0
HI_INC, 48, phase increment limit for x → 1 (HI_INC > LO_INC, < 2^(PHASE_BITS-1))
R_INIT, 272, reset value of r (1.0625)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mode  in  2  0 hold r, 1 sweep-up with wrap, 2 ping-pong, 3 pause
r_lo  in  2+FRAC  lower r bound
r_hi  in  2+FRAC  upper r bound (r_lo ≤ r_hi assumed by integrator)
r_step  in  2+FRAC  r increment per update
iter_per_r  in  16  iterations per r update; 0 is treated as 1
chan_en  in  N_OSC  mixer enable per oscillator
snd  out  1  sigma-delta audio
x_out  out  FRAC  current x
r_out  out  2+FRAC  current r
x_valid  out  1  one-cycle pulse on the cycle x_out takes a new value

Behaviour:
- Reset values: x = 2^(FRAC-1); r = R_INIT; ping-pong dir = up; divider, iteration counter, channel pointer, phases, and sigma-delta accumulator = 0; all freq registers = LO_INC; snd = 0; x_valid = 0.
- Pacing: div_cnt counts 0..ITER_DIV−1 and wraps. Tick = (div_cnt == ITER_DIV−1).
  - In mode 3, div_cnt holds and no ticks occur. x, r, and the counters freeze. Oscillators and mixer keep running.
- Map, computed on a tick using the current (old) r and x:
  - xc = 2^FRAC − x
  - t = (x·xc) >> FRAC
  - y = (r·t) >> FRAC
  - If y > 2^FRAC−1, saturate to 2^FRAC−1. If y == 0, force to 1.
  - x ← y at the tick edge. x_valid is high for exactly that following cycle. The first update occurs ITER_DIV clocks after reset deasserts.
- r update:
  - On a tick, iter_cnt increments. When iter_cnt reaches max(iter_per_r,1)−1, it clears and r updates on the same edge.
  - Mode 0: r unchanged.
  - Mode 1: if r < r_lo or r + r_step > r_hi, r ← r_lo; else r ← r + r_step. Sums use a 3+FRAC-bit intermediate, so there is no overflow.
  - Mode 2, dir up: if r + r_step ≥ r_hi, r ← r_hi and dir ← down; else r ← r + r_step.
  - Mode 2, dir down: if r ≤ r_lo + r_step, r ← r_lo and dir ← up; else r ← r − r_step.
  - Mode changes take effect at the next update; dir is retained across mode changes.
- Frequency mapping:
  - One cycle after x_valid, freq[ptr] ← LO_INC + (((HI_INC − LO_INC)·x) >> FRAC), using full-width intermediates.
  - ptr then advances, wrapping N_OSC−1 → 0.
- Oscillators:
  - A global step strobe fires every 2^PHASE_DEC clocks; the first fires at clock 2^PHASE_DEC−1 after reset.
  - On each strobe, phase[i] ← phase[i] + freq[i] mod 2^PHASE_BITS. osc[i] = phase[i] MSB.
- Mixer:
  - Each cycle, c = popcount(osc & chan_en) and s = acc + c.
  - If s ≥ N_OSC: acc ← s − N_OSC and snd ← 1. Else acc ← s and snd ← 0.
  - The density of snd equals c/N_OSC. All disabled gives snd = 0 constantly; all enabled and high gives snd = 1 constantly.
- Reset mid-operation returns every register to its reset value on the next edge. No partial iteration survives.

Test Plan:
1. FRAC=8, mode 0, R_INIT=512 (r=2.0), x=128 → every x_valid shows x_out=128; x_valid pulses are exactly ITER_DIV clocks apart, first at ITER_DIV after reset.
2. r=1023, x=128 → next x=255; the following iteration gives t=0 → x=1 (zero-forcing).
3. Mode 1, r_lo=256, r_hi=300, r_step=16, iter_per_r=2, R_INIT=256 → r_out sequence 272, 288, 256, 272, with each update every 2 ticks.
4. Mode 2, same bounds → r_out 272, 288, 300 (dir down), 284, 268, 256 (dir up), 272; then switch to mode 3 for 3·ITER_DIV clocks → no x_valid, x_out and r_out held.
5. N_OSC=4, x fixed at 128 → after 4 x_valid, all freq=28. With chan_en=4'b0000, snd stays 0. With chan_en=4'b1111, snd toggles with square-wave period 2^PHASE_BITS/28 strobes.
6. Assert reset for 1 cycle mid-sweep, with div_cnt mid-count and an oscillator phase nonzero → the next cycle shows x=128, r=R_INIT, snd=0, x_valid=0, and the first x_valid arrives ITER_DIV clocks later.

Source files
------------

// File: rtl/logistic_snd_multi.sv
// rtl/logistic_snd_multi.sv - logistic-map sonifier: paced fixed-point map, r sweep, oscillator bank, sigma-delta mix
module logistic_snd_multi #(
    parameter int N_OSC      = 4,
    parameter int FRAC       = 8,
    parameter int PHASE_BITS = 12,
    parameter int PHASE_DEC  = 7,
    parameter int ITER_DIV   = 4096,
    parameter int LO_INC     = 8,
    parameter int HI_INC     = 48,
    parameter int R_INIT     = 272
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic [FRAC+1:0]   r_lo,
    input  logic [FRAC+1:0]   r_hi,
    input  logic [FRAC+1:0]   r_step,
    input  logic [15:0]       iter_per_r,
    input  logic [N_OSC-1:0]  chan_en,
    output logic              snd,
    output logic [FRAC-1:0]   x_out,
    output logic [FRAC+1:0]   r_out,
    output logic              x_valid
);

    localparam int DW = $clog2(ITER_DIV);
    localparam int PW = (N_OSC > 1) ? $clog2(N_OSC) : 1;
    localparam int CW = $clog2(N_OSC + 1);
    localparam int AW = $clog2(2 * N_OSC);
    localparam int SW = PHASE_BITS + FRAC;

    localparam logic [DW-1:0]   DIV_LAST = DW'(ITER_DIV - 1);
    localparam logic [FRAC-1:0] X_INIT   = {1'b1, {(FRAC-1){1'b0}}};
    localparam logic [FRAC:0]   X_ONE    = {1'b1, {FRAC{1'b0}}};
    localparam logic [FRAC+3:0] X_MAX    = {4'b0000, {FRAC{1'b1}}};
    localparam logic [SW-1:0]   SPAN     = SW'(HI_INC - LO_INC);

    logic [FRAC-1:0]       x;
    logic [FRAC+1:0]       r;
    logic                  dir_up;
    logic [DW-1:0]         div_cnt;
    logic [15:0]           iter_cnt;
    logic [PW-1:0]         ptr;
    logic [PHASE_DEC-1:0]  step_cnt;
    logic [PHASE_BITS-1:0] phase [N_OSC];
    logic [PHASE_BITS-1:0] freq  [N_OSC];
    logic [AW-1:0]         acc;

    logic                  pause;
    logic                  tick;
    logic                  strobe;
    logic [15:0]           ipr_m1;

    assign x_out  = x;
    assign r_out  = r;
    assign pause  = (mode == 2'd3);
    assign tick   = !pause && (div_cnt == DIV_LAST);
    assign strobe = &step_cnt;
    assign ipr_m1 = (iter_per_r == 16'd0) ? 16'd0 : iter_per_r - 16'd1;

    // Map step y = r*x*(1-x), clamped to [1, 2^FRAC-1] so the orbit never sticks at 0.
    logic [FRAC:0]        xc;
    logic [2*FRAC+1:0]    prod1;
    logic [FRAC:0]        t;
    logic [2*FRAC+3:0]    prod2;
    logic [FRAC+3:0]      y_full;
    logic [FRAC-1:0]      y;

    always_comb begin
        xc     = X_ONE - {1'b0, x};
        prod1  = (2*FRAC+2)'(x) * (2*FRAC+2)'(xc);
        t      = (FRAC+1)'(prod1 >> FRAC);
        prod2  = (2*FRAC+4)'(r) * (2*FRAC+4)'(t);
        y_full = (FRAC+4)'(prod2 >> FRAC);
        if (y_full > X_MAX) begin
            y = '1;
        end else if (y_full == '0) begin
            y = FRAC'(1);
        end else begin
            y = y_full[FRAC-1:0];
        end
    end

    logic [FRAC+2:0] r_sum;
    logic [FRAC+2:0] lo_sum;
    logic [FRAC+1:0] r_next;
    logic            dir_next;

    always_comb begin
        r_sum    = {1'b0, r} + {1'b0, r_step};
        lo_sum   = {1'b0, r_lo} + {1'b0, r_step};
        r_next   = r;
        dir_next = dir_up;
        case (mode)
            2'd1: begin
                if ((r < r_lo) || (r_sum > {1'b0, r_hi})) begin
                    r_next = r_lo;
                end else begin
                    r_next = r_sum[FRAC+1:0];
                end
            end
            2'd2: begin
                if (dir_up) begin
                    if (r_sum >= {1'b0, r_hi}) begin
                        r_next   = r_hi;
                        dir_next = 1'b0;
                    end else begin
                        r_next = r_sum[FRAC+1:0];
                    end
                end else begin
                    if ({1'b0, r} <= lo_sum) begin
                        r_next   = r_lo;
                        dir_next = 1'b1;
                    end else begin
                        r_next = r - r_step;
                    end
                end
            end
            default: ;
        endcase
    end

    logic [SW-1:0]         span_x;
    logic [PHASE_BITS-1:0] freq_val;
    logic [CW-1:0]         c;
    logic [AW-1:0]         s;

    always_comb begin
        span_x   = SPAN * SW'(x);
        freq_val = PHASE_BITS'(LO_INC) + PHASE_BITS'(span_x >> FRAC);
        c = '0;
        for (int i = 0; i < N_OSC; i++) begin
            c = c + CW'(phase[i][PHASE_BITS-1] & chan_en[i]);
        end
        s = acc + AW'(c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x        <= X_INIT;
            r        <= (FRAC+2)'(R_INIT);
            dir_up   <= 1'b1;
            div_cnt  <= '0;
            iter_cnt <= '0;
            ptr      <= '0;
            step_cnt <= '0;
            acc      <= '0;
            snd      <= 1'b0;
            x_valid  <= 1'b0;
            for (int i = 0; i < N_OSC; i++) begin
                phase[i] <= '0;
                freq[i]  <= PHASE_BITS'(LO_INC);
            end
        end else begin
            if (!pause) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            end
            x_valid <= tick;
            if (tick) begin
                x <= y;
                if (iter_cnt >= ipr_m1) begin
                    iter_cnt <= '0;
                    r        <= r_next;
                    dir_up   <= dir_next;
                end else begin
                    iter_cnt <= iter_cnt + 16'd1;
                end
            end
            // The x_valid cycle already holds the new x, so the freq slot is loaded from it here.
            if (x_valid) begin
                freq[ptr] <= freq_val;
                ptr       <= (ptr == PW'(N_OSC - 1)) ? '0 : ptr + 1'b1;
            end
            step_cnt <= step_cnt + 1'b1;
            if (strobe) begin
                for (int i = 0; i < N_OSC; i++) begin
                    phase[i] <= phase[i] + freq[i];
                end
            end
            if (s >= AW'(N_OSC)) begin
                acc <= s - AW'(N_OSC);
                snd <= 1'b1;
            end else begin
                acc <= s;
                snd <= 1'b0;
            end
        end
    end

endmodule
